// File: rtl/my_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, ALU controls and the per-state control word.
package my_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BEQ      = 4'd8,
        ADDI_EX  = 4'd9,
        ADDI_WB  = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        aluop_t     aluop;
        logic       pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    // Moore control word for a state; anything not named stays 0.
    function automatic ctrl_t ctrl_for_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            DECODE:   c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD:    c.iord = 1'b1;
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            RTYPE_EX: begin
                c.alu_src_a = 1'b1;
                c.aluop     = ALUOP_FUNCT;
            end
            RTYPE_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BEQ: begin
                c.alu_src_a = 1'b1;
                c.aluop     = ALUOP_SUB;
                c.branch    = 1'b1;
                c.pc_src    = 1'b1;
            end
            ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDI_WB:  c.reg_write = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_control_alu_decoder.sv
// Maps the FSM's ALU operation class plus the funct field to the ALU control code.
module alu_decoder
    import my_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath. The control word is
// registered alongside the state; write enables are additionally gated by reset.
module multi_cycle_control
    import my_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP_i,
    input  logic [5:0] Funct_i,
    input  logic       ZERO_f_i,
    output logic       IorD_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ALUControl_o,
    output logic       PCSrc_o,
    output logic       PCEn_o,
    output logic [3:0] state_o
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (OP_i)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPE_EX;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDI_EX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (OP_i == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    state_d = MEMWB;
            RTYPE_EX: state_d = RTYPE_WB;
            ADDI_EX:  state_d = ADDI_WB;
            default:  state_d = FETCH;
        endcase
    end

    // Control word is computed from the next state so it lines up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_for_state(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for_state(state_d);
        end
    end

    alu_decoder u_alu_decoder (
        .aluop       (ctrl_q.aluop),
        .funct       (Funct_i),
        .alu_control (ALUControl_o)
    );

    // Gating with reset keeps every write enable low for the whole reset pulse.
    assign MemWrite_o = ctrl_q.mem_write & ~reset;
    assign IRWrite_o  = ctrl_q.ir_write & ~reset;
    assign RegWrite_o = ctrl_q.reg_write & ~reset;
    assign PCEn_o     = ~reset & (ctrl_q.pc_write | (ctrl_q.branch & ZERO_f_i));

    assign IorD_o     = ctrl_q.iord;
    assign RegDst_o   = ctrl_q.reg_dst;
    assign MemtoReg_o = ctrl_q.mem_to_reg;
    assign ALUSrcA_o  = ctrl_q.alu_src_a;
    assign ALUSrcB_o  = ctrl_q.alu_src_b;
    assign PCSrc_o    = ctrl_q.pc_src;
    assign state_o    = state_q;

endmodule
